// File: rtl/key_expand_pkg.sv
// Shared AES-128 key-schedule definitions: word/key types, FSM states,
// the round-constant table and the word-mixing helpers of the expansion.
package key_expand_pkg;

  typedef logic [7:0]   aes_byte_t;
  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_key_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ke_state_e;

  localparam int unsigned NUM_ROUNDS = 10;
  localparam logic [3:0]  LAST_ROUND = 4'd10;

  // Entry i is the constant used to derive round key i+1 from round key i.
  localparam aes_byte_t RCON [NUM_ROUNDS] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic aes_word_t rot_word(input aes_word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic aes_key_t next_round_key(input aes_key_t  cur,
                                              input aes_word_t sub_rot,
                                              input aes_byte_t rcon);
    aes_word_t t;
    aes_word_t n0;
    aes_word_t n1;
    aes_word_t n2;
    aes_word_t n3;
    t  = sub_rot ^ {rcon, 24'h000000};
    n0 = cur[127:96] ^ t;
    n1 = cur[95:64]  ^ n0;
    n2 = cur[63:32]  ^ n1;
    n3 = cur[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

endpackage

// File: rtl/key_expand_subword.sv
// SubWord: four parallel AES S-box lookups on a 32-bit word, purely
// combinational so the whole next round key settles within one cycle.
module key_expand_subword
  import key_expand_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  function automatic aes_byte_t sbox(input aes_byte_t b);
    aes_byte_t s;
    case (b)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b;
      8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b;
      8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d;
      8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf;
      8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26;
      8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1;
      8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3;
      8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2;
      8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a;
      8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3;
      8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed;
      8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39;
      8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb;
      8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f;
      8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f;
      8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21;
      8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec;
      8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d;
      8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc;
      8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14;
      8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a;
      8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62;
      8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d;
      8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea;
      8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e;
      8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f;
      8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66;
      8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9;
      8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11;
      8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9;
      8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d;
      8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f;
      8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  // Byte-wise substitution of the whole word.
  always_comb begin
    word_o = {sbox(word_i[31:24]), sbox(word_i[23:16]),
              sbox(word_i[15:8]),  sbox(word_i[7:0])};
  end

endmodule

// File: rtl/key_expand.sv
// AES-128 key expansion: accepts a cipher key and streams round keys 0..10
// over a valid/ready handshake, computing each next key in a single cycle.
module key_expand
  import key_expand_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk,
  output logic [3:0]   rk_round
);

  ke_state_e    state_q;
  ke_state_e    state_d;
  logic [127:0] rk_q;
  logic [127:0] rk_d;
  logic [3:0]   rk_round_q;
  logic [3:0]   rk_round_d;
  logic         rk_valid_q;
  logic         rk_valid_d;
  logic         key_ready_q;
  logic         key_ready_d;

  logic [31:0]  rot_s;
  logic [31:0]  sub_s;
  aes_byte_t    rcon_s;
  logic [127:0] next_rk_s;

  // RotWord of the last word feeds the S-box stage.
  always_comb begin
    rot_s = rot_word(rk_q[31:0]);
  end

  key_expand_subword u_subword (
    .word_i (rot_s),
    .word_o (sub_s)
  );

  // Round constant for deriving round key r+1; unused once round 10 is out.
  always_comb begin
    if (rk_round_q < LAST_ROUND) begin
      rcon_s = RCON[rk_round_q];
    end else begin
      rcon_s = 8'h00;
    end
  end

  // Next round key from the current one.
  always_comb begin
    next_rk_s = next_round_key(rk_q, sub_s, rcon_s);
  end

  // Handshake FSM: load key in IDLE, step through rounds on each transfer.
  always_comb begin
    state_d     = state_q;
    rk_d        = rk_q;
    rk_round_d  = rk_round_q;
    rk_valid_d  = rk_valid_q;
    key_ready_d = key_ready_q;
    case (state_q)
      ST_IDLE: begin
        if (key_valid && key_ready_q) begin
          state_d     = ST_RUN;
          rk_d        = key;
          rk_round_d  = 4'd0;
          rk_valid_d  = 1'b1;
          key_ready_d = 1'b0;
        end else begin
          state_d     = ST_IDLE;
          rk_valid_d  = 1'b0;
          key_ready_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (rk_valid_q && rk_ready) begin
          if (rk_round_q == LAST_ROUND) begin
            state_d     = ST_IDLE;
            rk_valid_d  = 1'b0;
            key_ready_d = 1'b1;
          end else begin
            rk_d        = next_rk_s;
            rk_round_d  = rk_round_q + 4'd1;
          end
        end else begin
          rk_d       = rk_q;
          rk_round_d = rk_round_q;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rk_d        = 128'h0;
        rk_round_d  = 4'd0;
        rk_valid_d  = 1'b0;
        key_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rk_q        <= 128'h0;
      rk_round_q  <= 4'd0;
      rk_valid_q  <= 1'b0;
      key_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      rk_q        <= rk_d;
      rk_round_q  <= rk_round_d;
      rk_valid_q  <= rk_valid_d;
      key_ready_q <= key_ready_d;
    end
  end

  assign key_ready = key_ready_q;
  assign rk_valid  = rk_valid_q;
  assign rk        = rk_q;
  assign rk_round  = rk_round_q;

endmodule

// File: doc/key_expand.md
KEY_EXPAND -- requirements
Module: key_expand

Interface
REQ-001 The block SHALL have no parameters; it is fixed to AES-128 (Nk=4, 10 rounds, 11 round keys).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 key_valid  in  1  cipher key offered.
REQ-006 key_ready  out  1  block idle and accepting a key.
REQ-007 key  in  128 (AESKey)  cipher key; bits [127:96] are w0; byte 0 is the MSB of each word.
REQ-008 rk_valid  out  1  round key presented.
REQ-009 rk_ready  in  1  consumer accepts the round key.
REQ-010 rk  out  128 (AESKey)  current round key, w[4r]..w[4r+3], MSB-first.
REQ-011 rk_round  out  4  index r of rk, 0..10.

Function
REQ-012 States SHALL be IDLE and RUN only.
REQ-013 IDLE: key_ready=1, rk_valid=0; a key is accepted when key_valid && key_ready; next state RUN, rk<=key, rk_round<=0.
REQ-014 RUN: key_ready=0, rk_valid=1; key_valid is ignored.
REQ-015 Latency: round key 0 SHALL be valid on the cycle after key acceptance.
REQ-016 In RUN, a transfer occurs when rk_valid && rk_ready; without a transfer rk and rk_round SHALL hold stable.
REQ-017 On a transfer with rk_round<10, rk SHALL update to the next round key and rk_round SHALL increment in the following cycle.
REQ-018 On a transfer with rk_round==10, the state SHALL return to IDLE, and a new key is accepted no earlier than the next cycle.
REQ-019 With rk_ready held high, the 11 round keys SHALL appear on 11 consecutive cycles.
REQ-020 Next round key: t = SubWord(RotWord(w3)) XOR {Rcon[r+1],00,00,00}; n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2.
REQ-021 The full next round key SHALL be computed in one cycle.
REQ-022 RotWord SHALL map bytes [b0,b1,b2,b3] to [b1,b2,b3,b0].
REQ-023 Rcon for rounds 1..10 SHALL be 01,02,04,08,10,20,40,80,1B,36 (hex).
REQ-024 All XORs SHALL be bitwise at 32 bits, with no carries.
REQ-025 rk_round SHALL never exceed 10 and SHALL never wrap.

Reset
REQ-026 When rst is asserted, in any state and at any cycle: state=IDLE, rk=0, rk_round=0, rk_valid=0, key_ready=1.
REQ-027 Reset mid-RUN SHALL abandon the expansion with no further rk transfer.
REQ-028 After rst deasserts, the block SHALL accept a new key immediately.

Structure
REQ-029 The shared defs package SHALL hold the AESByte, AESWord and AESKey types and the 10-entry Rcon constant table.
REQ-030 The block SHALL instantiate the team's existing subWord block (4 sbox lookups) as its only sub-module, fed by RotWord(w3).
REQ-031 All state SHALL be registered on clk with async rst; the next-key path SHALL be combinational.

Verification
REQ-032 Load key 2b7e151628aed2a6abf7158809cf4f3c with rk_ready=1 -> r1=a0fafe1788542cb123a339392a6c7605, r10=d014f9a8c9ee2589e13f0cc8b6630ca6, then key_ready=1 on the cycle after the r10 transfer.
REQ-033 Load the all-zero key -> r1=62636363626363636263636362636363, r10=b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-034 Random rk_ready backpressure (e.g. low 3 of every 4 cycles) -> rk and rk_round stable while stalled, the same 11 keys in order, and no key skipped or duplicated.
REQ-035 Pulse key_valid with a different key during RUN -> no effect; the sequence matches the original key and key_ready stays 0.
REQ-036 Assert rst while rk_round=5 -> the next cycle shows rk_valid=0, key_ready=1, rk_round=0; a fresh load then yields the correct r0..r10.
REQ-037 Back-to-back keys with key_valid held high -> the second key is accepted one cycle after the r10 transfer, and its r0 appears the cycle after that.
